reg_wb_arbiter: RTL and testbench

// Shares the single write port of reg_file between the execute (ALU) and load/store (LSU) writeback paths.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/reg_wb_arbiter_rr_arb2.sv | 42 ++++
 rtl/reg_wb_arbiter.sv | 102 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
//   DATA_WIDTH : writeback data width (reg_file data_wr)
//   ADDR_WIDTH : register index width
//   NUM_REGS   : number of architectural registers
//   wb_req_t   : one writeback request (destination + data)
//   rr_pri_e   : which requester a 2-way round-robin arbiter currently favours
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PRI_0 = 1'b0,
    PRI_1 = 1'b1
  } rr_pri_e;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests
//   gnt[1:0]   : one-hot grant, combinational from req and the priority pointer
// A grant is always an accepted handshake (gnt implies req), so the pointer
// moves to the other requester whenever any grant is issued.
//
// state | meaning
// PRI_0 | requester 0 wins a tie (reset state)
// PRI_1 | requester 1 wins a tie
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_pri_e pri_q, pri_d;

  always_comb begin
    gnt    = 2'b00;
    pri_d  = pri_q;
    gnt[0] = req[0] & (~req[1] | (pri_q == PRI_0));
    gnt[1] = req[1] & (~req[0] | (pri_q == PRI_1));
    if (gnt[0]) begin
      pri_d = PRI_1;
    end else if (gnt[1]) begin
      pri_d = PRI_0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the reg_file write port between the ALU and LSU
// writeback paths and tracks pending writes for RAW hazard stalls.
//   alu_* / lsu_*     : valid/ready writeback requests (ready is combinational)
//   alloc_valid/rd    : decode marks a destination busy at issue
//   flush             : clears the whole scoreboard at the next edge
//   qry_rs1/2, busy_* : combinational scoreboard lookups
//   wr_en/addr_wr/data_wr : registered write port to reg_file
module reg_wb_arbiter
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_rd,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] qry_rs1,
  input  logic [ADDR_WIDTH-1:0] qry_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr
);

  logic [1:0]            gnt;
  wb_req_t               alu_req, lsu_req, win_req;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  // Writes to x0 are accepted (and advance the arbiter) but never reach
  // reg_file; the port register keeps its previous address/data.
  always_comb begin
    alu_req   = '{rd: alu_rd, data: alu_data};
    lsu_req   = '{rd: lsu_rd, data: lsu_data};
    win_req   = gnt[1] ? lsu_req : alu_req;
    wr_en_d   = (|gnt) && (win_req.rd != '0);
    addr_wr_d = addr_wr_q;
    data_wr_d = data_wr_q;
    if (wr_en_d) begin
      addr_wr_d = win_req.rd;
      data_wr_d = win_req.data;
    end
  end

  // Clear on the reg_file commit edge, then set, so a new producer issued on
  // that same edge keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en_q) begin
        busy_d[addr_wr_q] = 1'b0;
      end
      if (alloc_valid && (alloc_rd != '0)) begin
        busy_d[alloc_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      addr_wr_q <= addr_wr_d;
      data_wr_q <= data_wr_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign addr_wr  = addr_wr_q;
  assign data_wr  = data_wr_q;
  assign busy_rs1 = busy_q[qry_rs1];
  assign busy_rs2 = busy_q[qry_rs2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        flush;
  logic [4:0]  qry_rs1, qry_rs2;
  logic        busy_rs1, busy_rs2;
  logic        wr_en;
  logic [4:0]  addr_wr;
  logic [31:0] data_wr;

  int n_checks = 0;
  int n_fail   = 0;

  reg_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .flush       (flush),
    .qry_rs1     (qry_rs1),
    .qry_rs2     (qry_rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .wr_en       (wr_en),
    .addr_wr     (addr_wr),
    .data_wr     (data_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    alloc_valid = 0; alloc_rd = 0; flush = 0;
    qry_rs1 = 0; qry_rs2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle_inputs();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0h want 0", wr_en); end
    n_checks++; if (addr_wr !== 5'd0) begin n_fail++; $display("FAIL reset_addr_wr: got %0h want 0", addr_wr); end
    n_checks++; if (data_wr !== 32'd0) begin n_fail++; $display("FAIL reset_data_wr: got %0h want 0", data_wr); end
    n_checks++; if (busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b%0b want 00", busy_rs1, busy_rs2); end
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_contention();
    logic        exp_alu;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    exp_alu = 1'b1;
    exp_addr = 0;
    exp_data = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) begin
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL contention_wr_en[%0d]: got %0h want 1", i, wr_en); end
        n_checks++; if (addr_wr !== exp_addr || data_wr !== exp_data) begin n_fail++; $display("FAIL contention_write[%0d]: got %0h/%0h want %0h/%0h", i, addr_wr, data_wr, exp_addr, exp_data); end
      end
      if (i < 4) begin
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h100 + i;
        lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h200 + i;
        #1;
        n_checks++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin n_fail++; $display("FAIL contention_grant[%0d]: got alu=%0b lsu=%0b want alu=%0b", i, alu_ready, lsu_ready, exp_alu); end
        exp_addr = exp_alu ? 5'd1 : 5'd2;
        exp_data = exp_alu ? (32'h100 + i) : (32'h200 + i);
        exp_alu = !exp_alu;
      end else begin
        alu_valid = 0; lsu_valid = 0;
      end
    end
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL contention_idle: got %0h want 0", wr_en); end
  endtask

  task automatic test_single_alu();
    tick();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got alu=%0b lsu=%0b want 1/0", alu_ready, lsu_ready); end
    tick();
    alu_valid = 0;
    n_checks++; if (wr_en !== 1'b1 || addr_wr !== 5'd5 || data_wr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_write: got %0h/%0h/%0h want 1/5/deadbeef", wr_en, addr_wr, data_wr); end
    tick();
    n_checks++; if (wr_en !== 1'b0 || addr_wr !== 5'd5 || data_wr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold: got %0h/%0h/%0h want 0/5/deadbeef", wr_en, addr_wr, data_wr); end
  endtask

  task automatic test_x0_drop();
    tick();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    #1;
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", lsu_ready); end
    tick();
    lsu_valid = 0;
    n_checks++; if (wr_en !== 1'b0 || addr_wr !== 5'd5 || data_wr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_no_write: got %0h/%0h/%0h want 0/5/deadbeef", wr_en, addr_wr, data_wr); end
    // LSU was granted last, so a tie now goes to the ALU.
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 32'hB;
    #1;
    n_checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL x0_pointer: got alu=%0b lsu=%0b want 1/0", alu_ready, lsu_ready); end
    tick();
    alu_valid = 0; lsu_valid = 0;
    tick();
  endtask

  task automatic test_scoreboard();
    alloc_valid = 1; alloc_rd = 5'd7; qry_rs1 = 5'd7; qry_rs2 = 5'd0;
    #1;
    n_checks++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_pre_alloc: got %0b want 0", busy_rs1); end
    tick();
    alloc_valid = 1; alloc_rd = 5'd0;
    #1;
    n_checks++; if (busy_rs1 !== 1'b1) begin n_fail++; $display("FAIL sb_alloc: got %0b want 1", busy_rs1); end
    alloc_valid = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL sb_wr_ready: got %0b want 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    n_checks++; if (busy_rs1 !== 1'b1 || wr_en !== 1'b1) begin n_fail++; $display("FAIL sb_n1: got busy=%0b wr_en=%0b want 1/1", busy_rs1, wr_en); end
    n_checks++; if (busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL sb_x0_never_busy: got %0b want 0", busy_rs2); end
    tick();
    n_checks++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_n2_clear: got %0b want 0", busy_rs1); end
    alloc_valid = 1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h78;
    #1;
    n_checks++; if (busy_rs1 !== 1'b1) begin n_fail++; $display("FAIL sb_realloc: got %0b want 1", busy_rs1); end
    tick();
    alu_valid = 0;
    alloc_valid = 1; alloc_rd = 5'd7;
    tick();
    alloc_valid = 0;
    #1;
    n_checks++; if (busy_rs1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %0b want 1", busy_rs1); end
  endtask

  task automatic test_flush();
    tick();
    alloc_valid = 1; alloc_rd = 5'd3;
    tick();
    alloc_rd = 5'd9;
    tick();
    alloc_valid = 0; qry_rs1 = 5'd3; qry_rs2 = 5'd9;
    #1;
    n_checks++; if (busy_rs1 !== 1'b1 || busy_rs2 !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0b%0b want 11", busy_rs1, busy_rs2); end
    flush = 1;
    alloc_valid = 1; alloc_rd = 5'd4;
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hAAAA_5555;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_handshake: got %0b want 1", alu_ready); end
    tick();
    flush = 0; alloc_valid = 0; alu_valid = 0;
    #1;
    n_checks++; if (busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got %0b%0b want 00", busy_rs1, busy_rs2); end
    n_checks++; if (wr_en !== 1'b1 || addr_wr !== 5'd12 || data_wr !== 32'hAAAA_5555) begin n_fail++; $display("FAIL flush_inflight: got %0h/%0h/%0h want 1/c/aaaa5555", wr_en, addr_wr, data_wr); end
    qry_rs1 = 5'd4; qry_rs2 = 5'd7;
    #1;
    n_checks++; if (busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL flush_alloc_ignored: got %0b%0b want 00", busy_rs1, busy_rs2); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
    alloc_valid = 1; alloc_rd = 5'd6; qry_rs1 = 5'd6;
    tick();
    alu_valid = 0; alloc_valid = 0;
    #1;
    n_checks++; if (wr_en !== 1'b1 || busy_rs1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got wr_en=%0b busy=%0b want 1/1", wr_en, busy_rs1); end
    rst_n = 0;
    #1;
    n_checks++; if (wr_en !== 1'b0 || addr_wr !== 5'd0 || data_wr !== 32'd0 || busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL rstmid: got %0h/%0h/%0h busy=%0b want 0/0/0/0", wr_en, addr_wr, data_wr, busy_rs1); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_random();
    bit          m_busy[32];
    bit          nb[32];
    bit          m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          favour_lsu;
    bit          alu_acc, lsu_acc, ea, el;
    idle_inputs();
    rst_n = 0;
    #1;
    rst_n = 1;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_wr = 0; m_addr = 0; m_data = 0; favour_lsu = 0;
    alu_acc = 0; lsu_acc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      n_checks++; if (wr_en !== m_wr || addr_wr !== m_addr || data_wr !== m_data) begin n_fail++; $display("FAIL rand_port[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", cyc, wr_en, addr_wr, data_wr, m_wr, m_addr, m_data); end
      if (!(alu_valid && !alu_acc)) begin
        alu_valid = ($urandom_range(0, 2) != 0); alu_rd = 5'($urandom_range(0, 15)); alu_data = $urandom;
      end
      if (!(lsu_valid && !lsu_acc)) begin
        lsu_valid = ($urandom_range(0, 2) != 0); lsu_rd = 5'($urandom_range(0, 15)); lsu_data = $urandom;
      end
      alloc_valid = $urandom_range(0, 1) != 0;
      alloc_rd = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 19) == 0);
      qry_rs1 = 5'($urandom_range(0, 15));
      qry_rs2 = 5'($urandom_range(0, 15));
      #1;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 0;
        #1;
        n_checks++; if (wr_en !== 1'b0 || addr_wr !== 5'd0 || data_wr !== 32'd0 || busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL rand_reset[%0d]: got %0h/%0h/%0h busy=%0b%0b want all 0", cyc, wr_en, addr_wr, data_wr, busy_rs1, busy_rs2); end
        rst_n = 1;
        #1;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_wr = 0; m_addr = 0; m_data = 0; favour_lsu = 0;
      end
      ea = alu_valid && (!lsu_valid || !favour_lsu);
      el = lsu_valid && (!alu_valid || favour_lsu);
      n_checks++; if (alu_ready !== ea || lsu_ready !== el) begin n_fail++; $display("FAIL rand_grant[%0d]: got %0b%0b want %0b%0b", cyc, alu_ready, lsu_ready, ea, el); end
      n_checks++; if (busy_rs1 !== m_busy[qry_rs1] || busy_rs2 !== m_busy[qry_rs2]) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0b%0b want %0b%0b", cyc, busy_rs1, busy_rs2, m_busy[qry_rs1], m_busy[qry_rs2]); end
      nb = m_busy;
      if (flush) begin
        foreach (nb[i]) nb[i] = 0;
      end else begin
        if (m_wr) nb[m_addr] = 0;
        if (alloc_valid && alloc_rd != 0) nb[alloc_rd] = 1;
      end
      m_busy = nb;
      if (ea || el) begin
        favour_lsu = ea;
        m_wr = ((ea ? alu_rd : lsu_rd) != 0);
        if (m_wr) begin
          m_addr = ea ? alu_rd : lsu_rd;
          m_data = ea ? alu_data : lsu_data;
        end
      end else begin
        m_wr = 0;
      end
      alu_acc = ea;
      lsu_acc = el;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_contention();
    test_single_alu();
    test_x0_drop();
    test_scoreboard();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
